// File: rtl/mem_datapath_seq_if.sv
// Command and memory-port bundles for mem_datapath_seq.
// cmd: master = control unit, slave = datapath. mem: master = datapath, slave = memory.
interface mds_cmd_if #(
  parameter int DW = 64,
  parameter int RA = 5
);
  logic          valid;
  logic          ready;
  logic [1:0]    kind;
  logic [2:0]    op;
  logic          ksel;
  logic          setf;
  logic [RA-1:0] sa;
  logic [RA-1:0] sb;
  logic [RA-1:0] da;
  logic [DW-1:0] k;

  modport master (output valid, kind, op, ksel, setf, sa, sb, da, k, input ready);
  modport slave  (input valid, kind, op, ksel, setf, sa, sb, da, k, output ready);
endinterface

interface mds_mem_if #(
  parameter int DW = 64,
  parameter int AW = 12
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_datapath_seq.sv
// Register file + ALU datapath that runs one command at a time and sequences
// loads/stores over a req/ack memory port with a timeout.
//   state  | meaning
//   S_IDLE | accepting commands; ALU/PCSEL complete here in one cycle
//   S_MEM  | memory access outstanding, waiting for ack or timeout
module mem_datapath_seq #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 12,
  parameter int REGS        = 32,
  parameter int ZERO_REG    = 1,
  parameter int MEM_TIMEOUT = 255,
  localparam int RA         = $clog2(REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  mds_cmd_if.slave              cmd,
  mds_mem_if.master             mem,
  output logic [DATA_WIDTH-1:0] pc_out_o,
  output logic                  pc_valid_o,
  output logic [3:0]            status_o,
  output logic                  busy_o,
  output logic                  err_o,
  input  logic [RA-1:0]         dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int TW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(MEM_TIMEOUT - 1);
  localparam logic [RA-1:0] ZR_ADDR  = RA'(REGS - 1);
  localparam bit ZR_EN = (ZERO_REG != 0);

  localparam logic [1:0] K_ALU = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10, K_PCSEL = 2'b11;

  typedef enum logic {S_IDLE, S_MEM} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [REGS];
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [RA-1:0]         da_q, da_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic [3:0]            status_q, status_d;
  logic                  err_q, err_d;

  logic                  wr_en;
  logic [RA-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  accept;

  logic [DATA_WIDTH-1:0] rs_a, rs_b, op_b, alu_f;
  logic [DATA_WIDTH:0]   sum_add, sum_sub;
  logic                  alu_c, alu_v;

  // XZR reads as zero on every read port
  assign rs_a       = (ZR_EN && cmd.sa == ZR_ADDR) ? '0 : regs_q[cmd.sa];
  assign rs_b       = (ZR_EN && cmd.sb == ZR_ADDR) ? '0 : regs_q[cmd.sb];
  assign dbg_data_o = (ZR_EN && dbg_addr_i == ZR_ADDR) ? '0 : regs_q[dbg_addr_i];

  assign accept  = cmd.valid && (state_q == S_IDLE);
  assign op_b    = cmd.ksel ? cmd.k : rs_b;
  assign sum_add = {1'b0, rs_a} + {1'b0, op_b};
  // carry out of A + ~B + 1 is set exactly when A >= B unsigned
  assign sum_sub = {1'b0, rs_a} + {1'b0, ~op_b} + (DATA_WIDTH+1)'(1);

  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (cmd.op)
      3'd0: begin
        alu_f = sum_add[DATA_WIDTH-1:0];
        alu_c = sum_add[DATA_WIDTH];
        alu_v = (rs_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                (alu_f[DATA_WIDTH-1] != rs_a[DATA_WIDTH-1]);
      end
      3'd1: begin
        alu_f = sum_sub[DATA_WIDTH-1:0];
        alu_c = sum_sub[DATA_WIDTH];
        alu_v = (rs_a[DATA_WIDTH-1] != op_b[DATA_WIDTH-1]) &&
                (alu_f[DATA_WIDTH-1] != rs_a[DATA_WIDTH-1]);
      end
      3'd2:    alu_f = rs_a & op_b;
      3'd3:    alu_f = rs_a | op_b;
      3'd4:    alu_f = rs_a ^ op_b;
      3'd5:    alu_f = op_b;
      3'd6:    alu_f = rs_a << op_b[SHW-1:0];
      default: alu_f = rs_a >> op_b[SHW-1:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    da_d       = da_q;
    pc_d       = pc_q;
    pc_valid_d = 1'b0;
    status_d   = status_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    wr_addr    = cmd.da;
    wr_data    = alu_f;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd.kind)
            K_ALU: begin
              wr_en = 1'b1;
              if (cmd.setf) status_d = {alu_v, alu_c, alu_f[DATA_WIDTH-1], alu_f == '0};
            end
            K_LOAD, K_STORE: begin
              addr_d  = rs_a[ADDR_WIDTH-1:0] + cmd.k[ADDR_WIDTH-1:0];
              we_d    = (cmd.kind == K_STORE);
              if (cmd.kind == K_STORE) wdata_d = rs_b;
              da_d    = cmd.da;
              tmo_d   = TMO_LOAD;
              state_d = S_MEM;
            end
            default: begin
              pc_d       = rs_a;
              pc_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_MEM: begin
        // an ack in the final timeout cycle still completes the access
        if (mem.ack) begin
          if (!we_q) begin
            wr_en   = 1'b1;
            wr_addr = da_q;
            wr_data = mem.rdata;
          end
          state_d = S_IDLE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      da_q       <= '0;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
      status_q   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      da_q       <= da_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      status_q   <= status_d;
      err_q      <= err_d;
      if (wr_en && !(ZR_EN && wr_addr == ZR_ADDR)) regs_q[wr_addr] <= wr_data;
    end
  end

  assign cmd.ready  = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign mem.req    = (state_q == S_MEM);
  assign mem.we     = we_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign pc_out_o   = pc_q;
  assign pc_valid_o = pc_valid_q;
  assign status_o   = status_q;
  assign err_o      = err_q;
endmodule
